ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25000000, system clock frequency used to derive all timing counts.
REQ-002 Parameter INHIBIT_US, default 100, duration the host holds PS/2 clock low before a request-to-send.
REQ-003 Parameter START_TIMEOUT_US, default 15000, maximum wait for the first device clock falling edge.
REQ-004 Parameter XFER_TIMEOUT_US, default 2000, maximum time from first device falling edge to end of ACK.
REQ-005 clk  input  1  system clock, sole clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 tx_data  input  8  byte to send to the device (command or argument, e.g. $ED).
REQ-008 tx_start  input  1  one-cycle request; accepted only while busy=0.
REQ-009 busy  output  1  high from the cycle after acceptance until done or error pulses.
REQ-010 done  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-011 error  output  1  one-cycle pulse: timeout or missing ACK.
REQ-012 ps2_clk_in, ps2_data_in  input  1 each  raw pad levels (asynchronous).
REQ-013 ps2_clk_oe, ps2_data_oe  output  1 each  1 = pull line low (open drain), 0 = release.
REQ-014 rx_inhibit  output  1  high while busy; tells the PS/2 receiver to ignore line activity.

Function
REQ-015 Each pad input SHALL pass through a 2-FF synchronizer and an 8-sample majority-free glitch filter: the filtered level changes only after 8 consecutive equal samples.
REQ-016 Falling edge of filtered clock (1->0) SHALL produce a one-cycle internal strobe fall.
REQ-017 States: IDLE, INHIBIT, RTS, BITS, ACK, RELEASE; encoding in package.
REQ-018 IDLE: both oe=0; on tx_start latch tx_data, compute odd parity (parity bit = ~^tx_data), clear counters, go INHIBIT.
REQ-019 INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles (2500 at defaults); last cycle asserts data_oe=1 and goes RTS.
REQ-020 RTS: clk_oe=0, data_oe=1 (start bit); on first fall, present bit 0 and go BITS; start-timeout counter expiry -> error.
REQ-021 BITS: frame index 0..9 = data[0..7] LSB first, parity, stop(1); data_oe = ~bit; each fall advances index; fall at index 9 -> ACK with data_oe=0.
REQ-022 ACK: on fall, sample filtered data; 0 -> RELEASE, 1 -> error.
REQ-023 RELEASE: wait for filtered clk=1 and data=1, then pulse done, go IDLE.
REQ-024 Transfer timeout counter starts at first fall and runs through RELEASE; expiry in any of those states -> error.
REQ-025 On error: both oe=0 in the same cycle, error pulses one cycle, return IDLE; done and error never both high.
REQ-026 tx_start while busy=1 SHALL be ignored (no queueing); tx_start in the cycle done/error pulses is ignored.
REQ-027 Counters SHALL be sized from the parameters ($clog2), never wrap before expiry.

Reset
REQ-028 rst SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0, rx_inhibit=0, filters to 1 (idle bus), counters to 0.
REQ-029 rst asserted mid-transfer SHALL release both lines in the next cycle and emit no done/error pulse.

Structure
REQ-030 Package ps2_pkg SHALL hold the state encoding, frame length (10), filter depth (8) and the microsecond-to-cycle conversion constant.
REQ-031 One sub-module ps2_line_filter (synchronizer + glitch filter + fall strobe) SHALL be instantiated once per line; the FSM stays in ps2_host_tx.

Verification (bench device model uses 40 us clock period; timeouts reduced via parameters)
REQ-032 tx_data=$ED, model ACKs -> line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses once; busy low after.
REQ-033 tx_data=$01 -> parity bit 0; tx_data=$00 -> parity bit 1; both done.
REQ-034 Model never clocks after RTS -> error exactly START_TIMEOUT cycles after entering RTS; both oe=0.
REQ-035 Model holds data high at ACK fall -> error, no done.
REQ-036 rst asserted after bit 4 -> next cycle oe=0, busy=0, no pulse; fresh tx_start=$F4 then completes normally.
REQ-037 1-cycle glitch on ps2_clk_in during BITS -> no bit advance; frame still correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, frame geometry
// and microsecond-to-cycle timing helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StBits,
        StAck,
        StRelease
    } ps2_state_e;

    // data[7:0], parity, stop
    localparam int unsigned FrameLen    = 10;
    localparam int unsigned FilterDepth = 8;

    localparam longint unsigned CyclesPerUsDivisor = 64'd1000000;

    // Rounds down; a zero-length interval is stretched to one cycle so terminal counts exist.
    function automatic int unsigned us_to_cycles(input longint unsigned clk_hz,
                                                 input longint unsigned us);
        longint unsigned cycles;
        cycles = (clk_hz * us) / CyclesPerUsDivisor;
        return (cycles == 64'd0) ? 32'd1 : 32'(cycles);
    endfunction

    // Width of a counter that runs 0 .. max_count-1.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 32'd1 : 32'($clog2(max_count));
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Pad conditioner for one PS/2 line: 2-FF synchronizer, 8-sample agreement filter
// and a registered one-cycle falling-edge strobe.
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic [1:0]             sync_q;
    logic [FilterDepth-1:0] hist_q;
    logic                   level_q;
    logic                   level_d;
    logic                   fall_q;

    // Level only moves once the whole history window agrees on the new value.
    always_comb begin
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], pad};
            hist_q  <= {hist_q[FilterDepth-2:0], sync_q[1]};
            level_q <= level_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, device-clocked
// frame shifting, ACK check and bus release, with start and transfer timeouts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 25000000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);

    localparam int unsigned InhibitCycles = us_to_cycles(64'(CLK_FREQ_HZ), 64'(INHIBIT_US));
    localparam int unsigned StartCycles   = us_to_cycles(64'(CLK_FREQ_HZ), 64'(START_TIMEOUT_US));
    localparam int unsigned XferCycles    = us_to_cycles(64'(CLK_FREQ_HZ), 64'(XFER_TIMEOUT_US));

    // One timer serves both INHIBIT and RTS, so it is sized for the longer of the two.
    localparam int unsigned TimerMax = (InhibitCycles > StartCycles) ? InhibitCycles : StartCycles;
    localparam int unsigned TimerW   = cnt_width(TimerMax);
    localparam int unsigned XferW    = cnt_width(XferCycles);
    localparam int unsigned IdxW     = cnt_width(FrameLen);

    localparam logic [TimerW-1:0] InhibitLast = TimerW'(InhibitCycles - 1);
    localparam logic [TimerW-1:0] StartLast   = TimerW'(StartCycles - 1);
    localparam logic [XferW-1:0]  XferLast    = XferW'(XferCycles - 1);
    localparam logic [IdxW-1:0]   LastIdx     = IdxW'(FrameLen - 1);

    ps2_state_e          state_q;
    ps2_state_e          state_d;
    logic [TimerW-1:0]   timer_q;
    logic [TimerW-1:0]   timer_d;
    logic [XferW-1:0]    xfer_q;
    logic [XferW-1:0]    xfer_d;
    logic [IdxW-1:0]     idx_q;
    logic [IdxW-1:0]     idx_d;
    logic [7:0]          data_q;
    logic [7:0]          data_d;
    logic                parity_q;
    logic                parity_d;
    logic                done_q;
    logic                done_d;
    logic                error_q;
    logic                error_d;
    logic                clk_oe_c;
    logic                data_oe_c;
    logic                xfer_expired;
    logic [FrameLen-1:0] frame;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    ps2_line_filter u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    assign frame        = {1'b1, parity_q, data_q};
    assign xfer_expired = (xfer_q == XferLast);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        xfer_d    = xfer_q;
        idx_d     = idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        clk_oe_c  = 1'b0;
        data_oe_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A start landing on the done/error pulse cycle is dropped, not queued.
                if (tx_start && !done_q && !error_q) begin
                    data_d   = tx_data;
                    parity_d = ~^tx_data;
                    timer_d  = '0;
                    xfer_d   = '0;
                    idx_d    = '0;
                    state_d  = StInhibit;
                end
            end

            StInhibit: begin
                clk_oe_c = 1'b1;
                if (timer_q == InhibitLast) begin
                    data_oe_c = 1'b1;
                    timer_d   = '0;
                    state_d   = StRts;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StRts: begin
                data_oe_c = 1'b1;
                if (clk_fall) begin
                    idx_d   = '0;
                    xfer_d  = '0;
                    state_d = StBits;
                end else if (timer_q == StartLast) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StBits: begin
                data_oe_c = ~frame[idx_q];
                if (xfer_expired) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    xfer_d = xfer_q + 1'b1;
                    if (clk_fall) begin
                        if (idx_q == LastIdx) begin
                            state_d = StAck;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end

            StAck: begin
                if (xfer_expired) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    xfer_d = xfer_q + 1'b1;
                    if (clk_fall) begin
                        if (!data_level) begin
                            state_d = StRelease;
                        end else begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end

            StRelease: begin
                if (xfer_expired) begin
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    xfer_d = xfer_q + 1'b1;
                    if (clk_level && data_level) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            xfer_q   <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            xfer_q   <= xfer_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign rx_inhibit  = busy;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_c;
    assign ps2_data_oe = data_oe_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device on open-drain lines, frame
// scoreboard, and timeout, missing-ACK, mid-transfer reset and glitch scenarios.
module tb_ps2_host_tx;

    localparam int unsigned ClkHz       = 2000000;
    localparam int unsigned InhibitUs   = 100;
    localparam int unsigned StartUs     = 500;
    localparam int unsigned XferUs      = 2000;
    localparam int          CyclesPerUs = ClkHz / 1000000;
    localparam int          StartCycles = StartUs * CyclesPerUs;
    localparam int          Half        = 20 * CyclesPerUs;  // 40 us device clock period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       busy;
    logic       done;
    logic       error;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       rx_inhibit;

    logic dev_clk    = 1'b1;
    logic dev_data   = 1'b1;
    logic dev_glitch = 1'b0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe & ~dev_glitch;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ      (ClkHz),
        .INHIBIT_US       (InhibitUs),
        .START_TIMEOUT_US (StartUs),
        .XFER_TIMEOUT_US  (XferUs)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .rx_inhibit  (rx_inhibit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;
    logic [10:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (error) n_err <= n_err + 1;
        if (done && error) n_both <= n_both + 1;
    end

    // Line image: start(0), data LSB first, odd parity, stop(1).
    function automatic logic [10:0] expected_frame(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic pulse_start(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Device side: waits for RTS, clocks the frame, samples on rising edges.
    task automatic device_xfer(input int stop_after_rise, input bit ack, input int glitch_rise,
                               output logic [10:0] frame, output bit saw_rts);
        int t;
        frame   = '0;
        saw_rts = 1'b0;
        t       = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) return;
        saw_rts = 1'b1;
        repeat (30) @(negedge clk);
        frame[0] = ps2_data_in;
        for (int f = 1; f <= 12; f++) begin
            dev_clk = 1'b0;
            repeat (Half) @(negedge clk);
            if (f <= 10) frame[f] = ps2_data_in;
            dev_clk = 1'b1;
            if (f == 11 && ack) dev_data = 1'b0;
            if (f == 12) begin
                dev_data = 1'b1;
                return;
            end
            if (f == stop_after_rise) return;
            if (f == glitch_rise) begin
                repeat (15) @(negedge clk);
                dev_glitch = 1'b1;
                @(negedge clk);
                dev_glitch = 1'b0;
                repeat (Half - 16) @(negedge clk);
            end else begin
                repeat (Half) @(negedge clk);
            end
        end
    endtask

    task automatic wait_outcome(input bit poke, output bit got_done, output bit got_err,
                                output bit busy_at);
        got_done = 1'b0;
        got_err  = 1'b0;
        busy_at  = 1'b1;
        for (int i = 0; i < 500 && !got_done && !got_err; i++) begin
            @(negedge clk);
            got_done = done;
            got_err  = error;
            busy_at  = busy;
            if ((done || error) && poke) begin
                tx_data  = 8'h3C;
                tx_start = 1'b1;
            end
        end
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
        n_checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
        n_checks++; if (rx_inhibit !== 1'b0) $display("FAIL reset_rx_inhibit: got %b want 0", rx_inhibit); else n_pass++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_frame(input logic [7:0] b, input string name, input bit exp_parity,
                              input bit poke_busy, input int glitch_rise);
        logic [10:0] got;
        logic [10:0] want;
        bit saw, gd, ge, bz;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        exp_q.push_back(expected_frame(b));
        pulse_start(b);
        n_checks++; if (busy !== 1'b1 || rx_inhibit !== 1'b1) $display("FAIL %s_busy_on_accept: got busy=%b inh=%b want 1/1", name, busy, rx_inhibit); else n_pass++;
        if (poke_busy) begin
            repeat (20) @(negedge clk);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        device_xfer(0, 1'b1, glitch_rise, got, saw);
        want = exp_q.pop_front();
        n_checks++; if (!saw) $display("FAIL %s_rts: got no RTS want RTS", name); else n_pass++;
        n_checks++; if (got !== want) $display("FAIL %s_frame: got %b want %b", name, got, want); else n_pass++;
        n_checks++; if (got[9] !== exp_parity) $display("FAIL %s_parity: got %b want %b", name, got[9], exp_parity); else n_pass++;
        wait_outcome(1'b1, gd, ge, bz);
        n_checks++; if (gd !== 1'b1) $display("FAIL %s_done: got %b want 1", name, gd); else n_pass++;
        n_checks++; if (ge !== 1'b0) $display("FAIL %s_no_error: got %b want 0", name, ge); else n_pass++;
        n_checks++; if (bz !== 1'b0) $display("FAIL %s_busy_at_done: got %b want 0", name, bz); else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL %s_start_on_pulse_ignored: got busy=%b want 0", name, busy); else n_pass++;
        n_checks++; if (n_done - d0 !== 1) $display("FAIL %s_done_count: got %0d want 1", name, n_done - d0); else n_pass++;
        n_checks++; if (n_err !== e0) $display("FAIL %s_error_count: got %0d want 0", name, n_err - e0); else n_pass++;
    endtask

    task automatic test_ed_literal();
        logic [10:0] lit;
        lit = 11'b1_1_11101101_0;
        n_checks++; if (expected_frame(8'hED) !== lit) $display("FAIL ed_model: got %b want %b", expected_frame(8'hED), lit); else n_pass++;
        test_frame(8'hED, "ed", 1'b1, 1'b1, 0);
    endtask

    task automatic test_start_timeout();
        int t, t_rts, t_err, d0, e0;
        d0 = n_done;
        e0 = n_err;
        pulse_start(8'h12);
        t = 0;
        while (!(ps2_data_oe && !ps2_clk_oe) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        t_rts = cyc;
        t = 0;
        while (!error && t < StartCycles + 200) begin
            @(negedge clk);
            t++;
        end
        t_err = cyc;
        n_checks++; if (error !== 1'b1) $display("FAIL start_timeout_error: got %b want 1", error); else n_pass++;
        n_checks++; if (t_err - t_rts !== StartCycles) $display("FAIL start_timeout_latency: got %0d want %0d", t_err - t_rts, StartCycles); else n_pass++;
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL start_timeout_oe: got %b%b want 00", ps2_clk_oe, ps2_data_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL start_timeout_busy: got %b want 0", busy); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (n_err - e0 !== 1) $display("FAIL start_timeout_err_count: got %0d want 1", n_err - e0); else n_pass++;
        n_checks++; if (n_done !== d0) $display("FAIL start_timeout_no_done: got %0d want 0", n_done - d0); else n_pass++;
    endtask

    task automatic test_no_ack();
        logic [10:0] got;
        logic [10:0] want;
        bit saw;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        exp_q.push_back(expected_frame(8'h5A));
        pulse_start(8'h5A);
        device_xfer(0, 1'b0, 0, got, saw);
        want = exp_q.pop_front();
        n_checks++; if (got !== want) $display("FAIL no_ack_frame: got %b want %b", got, want); else n_pass++;
        repeat (100) @(negedge clk);
        n_checks++; if (n_err - e0 !== 1) $display("FAIL no_ack_err_count: got %0d want 1", n_err - e0); else n_pass++;
        n_checks++; if (n_done !== d0) $display("FAIL no_ack_no_done: got %0d want 0", n_done - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL no_ack_idle: got busy=%b oe=%b%b want 0/00", busy, ps2_clk_oe, ps2_data_oe); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        logic [10:0] want;
        bit saw;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        want = expected_frame(8'h9A);
        pulse_start(8'h9A);
        device_xfer(5, 1'b1, 0, got, saw);
        n_checks++; if (got[5:0] !== want[5:0]) $display("FAIL reset_mid_prefix: got %b want %b", got[5:0], want[5:0]); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL reset_mid_oe: got %b%b want 00", ps2_clk_oe, ps2_data_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0 || rx_inhibit !== 1'b0) $display("FAIL reset_mid_busy: got %b/%b want 0/0", busy, rx_inhibit); else n_pass++;
        rst = 1'b0;
        repeat (100) @(negedge clk);
        n_checks++; if (n_done !== d0 || n_err !== e0) $display("FAIL reset_mid_no_pulse: got done+%0d err+%0d want 0/0", n_done - d0, n_err - e0); else n_pass++;
        test_frame(8'hF4, "after_reset", 1'b0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_ed_literal();
        test_frame(8'h01, "x01", 1'b0, 1'b0, 0);
        test_frame(8'h00, "x00", 1'b1, 1'b0, 0);
        test_start_timeout();
        test_no_ack();
        test_reset_mid();
        test_frame(8'hA5, "glitch", 1'b1, 1'b0, 4);
        n_checks++; if (n_both !== 0) $display("FAIL done_error_overlap: got %0d want 0", n_both); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
